// File: rtl/code_queue.sv
// ----------------------------------------------------------------------------
// code_queue
//
// Captures codes from an upstream 4-to-2 encoder and queues each *new* code
// in a small show-ahead FIFO. A code is considered new when it is valid and
// either the previous sample was invalid or the code changed. Holding one
// code therefore enqueues it once only.
//
// Optional feature (macro CODE_QUEUE_HIST_EN):
//   When defined, four 8-bit saturating hit counters count each accepted
//   code value. When undefined, the counters are not built and hist reads 0.
//
// Parameters:
//   DEPTH     FIFO entry count; power of two, 2..16 (default 4)
//
// Ports:
//   clk       input   clock; all state changes on the rising edge
//   rst_n     input   synchronous active-low reset
//   code_in   input   [1:0] encoded code from the upstream encoder
//   code_vld  input   at least one encoder request line is active
//   out_rdy   input   downstream can accept the head entry
//   out_code  output  [1:0] head entry code, 0 when empty
//   out_vld   output  head entry valid (FIFO not empty)
//   count     output  [log2(DEPTH):0] occupancy, 0..DEPTH
//   ovf       output  sticky overflow flag, cleared only by reset
//   hist      output  [31:0] per-code hit counters, bits [8k+7:8k] = code k
//
// Handshake: the head entry is transferred on a rising edge where
// out_vld=1 and out_rdy=1. out_vld never depends on out_rdy, and out_code
// is stable while out_vld=1 and no transfer takes place. out_rdy has no
// effect while out_vld=0.
// ----------------------------------------------------------------------------
module code_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               code_in,
    input  logic                     code_vld,
    input  logic                     out_rdy,
    output logic [1:0]               out_code,
    output logic                     out_vld,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [31:0]              hist
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Storage and pointers. DEPTH is a power of two, so the pointers wrap
    // modulo DEPTH simply by overflowing their natural width.
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          ovf_q;

    // Previous-sample register used for change detection.
    logic [1:0]    last_code;
    logic          last_vld;

    logic          push_req;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // A request is a valid code that is new relative to the last sample.
    assign push_req = code_vld && (!last_vld || (code_in != last_code));
    assign full     = (cnt == FULL_CNT);
    assign pop      = out_vld && out_rdy;
    // When full, a same-edge pop frees the slot the push lands in.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_code <= 2'd0;
            last_vld  <= 1'b0;
        end else begin
            last_code <= code_in;
            last_vld  <= code_vld;
        end
    end

    // Entry storage is not reset: the occupancy count alone decides which
    // entries are live, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= code_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Show-ahead output: the head entry is visible combinationally from the
    // registered read pointer, with no read latency.
    assign out_vld  = (cnt != '0);
    assign out_code = out_vld ? mem[rd_ptr] : 2'd0;
    assign count    = cnt;
    assign ovf      = ovf_q;

`ifdef CODE_QUEUE_HIST_EN
    // One saturating counter per code value; only accepted pushes count.
    logic [7:0] hist_cnt [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                hist_cnt[k] <= 8'd0;
            end
        end else if (push && (hist_cnt[code_in] != 8'hFF)) begin
            hist_cnt[code_in] <= hist_cnt[code_in] + 8'd1;
        end
    end

    assign hist = {hist_cnt[3], hist_cnt[2], hist_cnt[1], hist_cnt[0]};
`else
    assign hist = 32'd0;
`endif

endmodule

// File: tb/tb_code_queue.sv
// ----------------------------------------------------------------------------
// tb_code_queue
//
// Directed bench for code_queue (DEPTH=4). The driver issues hand-written
// vectors and, for each vector that must enqueue, pushes the code onto an
// expected queue. A separate monitor pops that queue whenever the DUT
// transfers its head entry and compares the code. Occupancy, overflow and
// histogram values are compared against hand-computed constants.
// ----------------------------------------------------------------------------
module tb_code_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  code_in;
    logic        code_vld;
    logic        out_rdy;
    logic [1:0]  out_code;
    logic        out_vld;
    logic [2:0]  count;
    logic        ovf;
    logic [31:0] hist;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] exp_q[$];

    code_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .code_in  (code_in),
        .code_vld (code_vld),
        .out_rdy  (out_rdy),
        .out_code (out_code),
        .out_vld  (out_vld),
        .count    (count),
        .ovf      (ovf),
        .hist     (hist)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when out_vld and
    // out_rdy are both high with reset released.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL pop_unexpected: got code %0d, expected no entry at %0t",
                         out_code, $time);
            end else begin
                check("pop_code", {30'd0, out_code}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [1:0] c, input logic v, input logic r, input logic exp_push);
        code_in  = c;
        code_vld = v;
        out_rdy  = r;
        if (exp_push) exp_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n    = 1'b0;
        code_vld = 1'b0;
        code_in  = 2'd0;
        out_rdy  = 1'b0;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) step(2'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        code_in  = 2'd0;
        code_vld = 1'b0;
        out_rdy  = 1'b0;

        // Reset state
        do_reset(2);
        check("rst_count",    {29'd0, count}, 32'd0);
        check("rst_out_vld",  {31'd0, out_vld}, 32'd0);
        check("rst_out_code", {30'd0, out_code}, 32'd0);
        check("rst_ovf",      {31'd0, ovf}, 32'd0);
        check("rst_hist",     hist, 32'd0);
        release_reset();

        // Held code pushes once; first valid after reset pushes
        step(2'd2, 1'b1, 1'b0, 1'b1);
        check("lat_count", {29'd0, count}, 32'd1);
        check("lat_out_vld", {31'd0, out_vld}, 32'd1);
        repeat (4) step(2'd2, 1'b1, 1'b0, 1'b0);
        check("hold_count", {29'd0, count}, 32'd1);
        check("hold_out_code", {30'd0, out_code}, 32'd2);
        check("hold_out_vld", {31'd0, out_vld}, 32'd1);
        drain(1);
        check("hold_drained", {29'd0, count}, 32'd0);

        // Fill 0,1,2,3 then push 1 into a full FIFO
        step(2'd0, 1'b1, 1'b0, 1'b1);
        step(2'd1, 1'b1, 1'b0, 1'b1);
        step(2'd2, 1'b1, 1'b0, 1'b1);
        step(2'd3, 1'b1, 1'b0, 1'b1);
        check("full_ovf_before", {31'd0, ovf}, 32'd0);
        step(2'd1, 1'b1, 1'b0, 1'b0);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_ovf", {31'd0, ovf}, 32'd1);
        check("full_head", {30'd0, out_code}, 32'd0);
        drain(4);
        check("ovf_drained_count", {29'd0, count}, 32'd0);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        check("empty_out_code", {30'd0, out_code}, 32'd0);

        // Reset clears ovf
        do_reset(1);
        release_reset();
        check("ovf_cleared", {31'd0, ovf}, 32'd0);

        // Full FIFO with same-edge push and pop
        step(2'd0, 1'b1, 1'b0, 1'b1);
        step(2'd1, 1'b1, 1'b0, 1'b1);
        step(2'd2, 1'b1, 1'b0, 1'b1);
        step(2'd3, 1'b1, 1'b0, 1'b1);
        step(2'd2, 1'b1, 1'b1, 1'b1);
        step(2'd2, 1'b0, 1'b0, 1'b0);
        check("pp_full_count", {29'd0, count}, 32'd4);
        check("pp_full_ovf", {31'd0, ovf}, 32'd0);
        check("pp_full_head", {30'd0, out_code}, 32'd1);
        drain(4);

        // code_vld toggled 1,0,1 with code 3 gives two pushes
        step(2'd3, 1'b1, 1'b0, 1'b1);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        step(2'd3, 1'b1, 1'b0, 1'b1);
        check("toggle_count", {29'd0, count}, 32'd2);
        drain(2);

        // out_rdy while empty has no effect
        drain(2);
        check("empty_rdy_count", {29'd0, count}, 32'd0);
        check("empty_rdy_vld", {31'd0, out_vld}, 32'd0);

        // Mid-operation reset discards three queued entries
        step(2'd1, 1'b1, 1'b0, 1'b1);
        step(2'd2, 1'b1, 1'b0, 1'b1);
        step(2'd3, 1'b1, 1'b0, 1'b1);
        check("pre_rst_count", {29'd0, count}, 32'd3);
        do_reset(1);
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_vld", {31'd0, out_vld}, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        release_reset();
        // Code 0 equals the cleared last_code, but last_vld=0 forces a push
        step(2'd0, 1'b1, 1'b0, 1'b1);
        check("first_after_rst", {29'd0, count}, 32'd1);
        drain(1);

        // Histogram: 300 alternating pushes of 1 and 2, streaming out
        do_reset(1);
        release_reset();
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 2'd1 : 2'd2, 1'b1, 1'b1, 1'b1);
        end
`ifdef CODE_QUEUE_HIST_EN
        check("hist_code0_a", {24'd0, hist[7:0]},   32'd0);
        check("hist_code1_a", {24'd0, hist[15:8]},  32'd150);
        check("hist_code2_a", {24'd0, hist[23:16]}, 32'd150);
        check("hist_code3_a", {24'd0, hist[31:24]}, 32'd0);
`else
        check("hist_off_a", hist, 32'd0);
`endif
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 2'd1 : 2'd2, 1'b1, 1'b1, 1'b1);
        end
`ifdef CODE_QUEUE_HIST_EN
        check("hist_code1_sat", {24'd0, hist[15:8]},  32'd255);
        check("hist_code2_sat", {24'd0, hist[23:16]}, 32'd255);
`else
        check("hist_off_b", hist, 32'd0);
`endif
        drain(2);
        check("final_count", {29'd0, count}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
